// File: rtl/rf_hilo_unit_pkg.sv
// Shared widths, bus layouts and read-mux helper for the register file / HI-LO block.
// Same-cycle write-through bypass is compiled in only when RF_HILO_BYPASS_EN is defined.
package rf_hilo_unit_pkg;

    localparam int NREG      = 32;
    localparam int DW        = 32;
    localparam int RegAddrBus = $clog2(NREG);
    localparam int RegBus    = DW;

    localparam logic [RegBus-1:0] ZeroWord = 32'h0;

    // WB -> RF write bus: {we[37], waddr[36:32], wdata[31:0]}
    localparam int WB_TO_RF_WD    = 38;
    localparam int RF_WE_BIT      = 37;
    localparam int RF_WADDR_MSB   = 36;
    localparam int RF_WADDR_LSB   = 32;
    localparam int RF_WDATA_MSB   = 31;
    localparam int RF_WDATA_LSB   = 0;

    // WB -> HI/LO write bus: {hi_we[65], lo_we[64], hi_i[63:32], lo_i[31:0]}
    localparam int WB_TO_HILO     = 66;
    localparam int HILO_HI_WE_BIT = 65;
    localparam int HILO_LO_WE_BIT = 64;
    localparam int HILO_HI_MSB    = 63;
    localparam int HILO_HI_LSB    = 32;
    localparam int HILO_LO_MSB    = 31;
    localparam int HILO_LO_LSB    = 0;

    // Field order mirrors the bus bit layout, so a plain cast unpacks it.
    typedef struct packed {
        logic                  we;
        logic [RegAddrBus-1:0] waddr;
        logic [RegBus-1:0]     wdata;
    } rf_wr_t;

    typedef struct packed {
        logic              hi_we;
        logic              lo_we;
        logic [RegBus-1:0] hi_i;
        logic [RegBus-1:0] lo_i;
    } hilo_wr_t;

    // One GPR read port: r0 is hard-wired zero, then optional bypass, then storage.
    function automatic logic [RegBus-1:0] gpr_read(
        input logic [RegAddrBus-1:0] raddr,
        input logic                  bypass_en,
        input rf_wr_t                wr,
        input logic [RegBus-1:0]     stored
    );
        logic [RegBus-1:0] val;
        val = stored;
        if (raddr == '0) begin
            val = ZeroWord;
        end else if (bypass_en && wr.we && (wr.waddr == raddr)) begin
            val = wr.wdata;
        end
        return val;
    endfunction

endpackage

// File: rtl/rf_hilo_unit_if.sv
// Write-back and read-port signal bundle between the pipeline (master) and the
// architectural state block (slave).
interface rf_hilo_unit_if;
    import rf_hilo_unit_pkg::*;

    // No valid/ready handshake: every cycle the slave commits whatever the write
    // buses carry (we/hi_we/lo_we low means a bubble) and reads are combinational.
    logic [WB_TO_RF_WD-1:0] wb_to_rf_bus;
    logic [WB_TO_HILO-1:0]  wb_to_hilo_bus;
    logic [RegAddrBus-1:0]  raddr1;
    logic [RegAddrBus-1:0]  raddr2;
    logic [RegBus-1:0]      rdata1;
    logic [RegBus-1:0]      rdata2;
    logic [RegBus-1:0]      hi_o;
    logic [RegBus-1:0]      lo_o;
    logic [31:0]            commit_cnt;

    modport master (
        output wb_to_rf_bus,
        output wb_to_hilo_bus,
        output raddr1,
        output raddr2,
        input  rdata1,
        input  rdata2,
        input  hi_o,
        input  lo_o,
        input  commit_cnt
    );

    modport slave (
        input  wb_to_rf_bus,
        input  wb_to_hilo_bus,
        input  raddr1,
        input  raddr2,
        output rdata1,
        output rdata2,
        output hi_o,
        output lo_o,
        output commit_cnt
    );

endinterface

// File: rtl/rf_hilo_unit_hilo_reg.sv
// HI/LO storage with independent write enables and its read-side bypass muxes.
// Bypass muxes exist only when RF_HILO_BYPASS_EN is defined.
module hilo_reg
    import rf_hilo_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  hilo_wr_t          wr,
    output logic [RegBus-1:0] hi_o,
    output logic [RegBus-1:0] lo_o
);

    logic [RegBus-1:0] hi_q;
    logic [RegBus-1:0] lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= ZeroWord;
            lo_q <= ZeroWord;
        end else begin
            if (wr.hi_we) begin
                hi_q <= wr.hi_i;
            end
            if (wr.lo_we) begin
                lo_q <= wr.lo_i;
            end
        end
    end

`ifdef RF_HILO_BYPASS_EN
    assign hi_o = wr.hi_we ? wr.hi_i : hi_q;
    assign lo_o = wr.lo_we ? wr.lo_i : lo_q;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

endmodule

// File: rtl/rf_hilo_unit.sv
// Architectural GPR file, HI/LO pair and retired-write counter at the end of WB.
// Define RF_HILO_BYPASS_EN to make same-cycle writes visible on the read ports.
module rf_hilo_unit
    import rf_hilo_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    rf_hilo_unit_if.slave bus
);

`ifdef RF_HILO_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    rf_wr_t            rf_wr;
    hilo_wr_t          hilo_wr;
    logic              gpr_commit;
    logic [RegBus-1:0] regs [NREG];
    logic [31:0]       commit_q;
    logic [RegBus-1:0] rdata1_d;
    logic [RegBus-1:0] rdata2_d;

    assign rf_wr      = rf_wr_t'(bus.wb_to_rf_bus);
    assign hilo_wr    = hilo_wr_t'(bus.wb_to_hilo_bus);
    assign gpr_commit = rf_wr.we && (rf_wr.waddr != '0);

    // Entry 0 is never written, so after reset it stays zero; reads of r0 are
    // forced to zero anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= ZeroWord;
            end
        end else if (gpr_commit) begin
            regs[rf_wr.waddr] <= rf_wr.wdata;
        end
    end

    // Counts only GPR writes that actually change architectural state.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_q <= '0;
        end else if (gpr_commit) begin
            commit_q <= commit_q + 32'd1;
        end
    end

    always_comb begin
        rdata1_d = gpr_read(bus.raddr1, BYPASS_EN, rf_wr, regs[bus.raddr1]);
    end

    always_comb begin
        rdata2_d = gpr_read(bus.raddr2, BYPASS_EN, rf_wr, regs[bus.raddr2]);
    end

    assign bus.rdata1     = rdata1_d;
    assign bus.rdata2     = rdata2_d;
    assign bus.commit_cnt = commit_q;

    hilo_reg u_hilo_reg (
        .clk  (clk),
        .rst  (rst),
        .wr   (hilo_wr),
        .hi_o (bus.hi_o),
        .lo_o (bus.lo_o)
    );

endmodule

// File: tb/tb_rf_hilo_unit.sv
// Randomized + directed scoreboard bench for rf_hilo_unit against an array-based model.
// Bypass expectations follow RF_HILO_BYPASS_EN, matching the build of the design.
module tb_rf_hilo_unit;

`ifdef RF_HILO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam int W = 160;

    logic clk;
    logic rst;

    rf_hilo_unit_if ifc ();

    rf_hilo_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [31:0] gpr_m [32];
    logic [31:0] hi_m;
    logic [31:0] lo_m;
    logic [31:0] cnt_m;

    // scoreboard
    logic [W-1:0] exp_q[$];
    int n_cmp;
    int n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: outputs are combinational, sampled just before each posedge
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rdata1",     ifc.rdata1,     e[159:128]);
                check("rdata2",     ifc.rdata2,     e[127:96]);
                check("hi_o",       ifc.hi_o,       e[95:64]);
                check("lo_o",       ifc.lo_o,       e[63:32]);
                check("commit_cnt", ifc.commit_cnt, e[31:0]);
            end
        end
    end

    // driver: one cycle of stimulus; expectation pushed, then model advanced
    task automatic cycle(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input bit hwe, input bit lwe, input logic [31:0] hi, input logic [31:0] lo,
                         input logic [4:0] a1, input logic [4:0] a2, input bit chk);
        logic [31:0] e1, e2, eh, el;
        @(negedge clk);
        rst                = r;
        ifc.wb_to_rf_bus   = {we, wa, wd};
        ifc.wb_to_hilo_bus = {hwe, lwe, hi, lo};
        ifc.raddr1         = a1;
        ifc.raddr2         = a2;
        e1 = (a1 == 0) ? 32'h0 : (BYPASS && we && wa == a1) ? wd : gpr_m[a1];
        e2 = (a2 == 0) ? 32'h0 : (BYPASS && we && wa == a2) ? wd : gpr_m[a2];
        eh = (BYPASS && hwe) ? hi : hi_m;
        el = (BYPASS && lwe) ? lo : lo_m;
        if (chk) exp_q.push_back({e1, e2, eh, el, cnt_m});
        if (r) begin
            for (int i = 0; i < 32; i++) gpr_m[i] = 32'h0;
            hi_m  = 32'h0;
            lo_m  = 32'h0;
            cnt_m = 32'h0;
        end else begin
            if (we && wa != 0) begin
                gpr_m[wa] = wd;
                cnt_m     = cnt_m + 1;
            end
            if (hwe) hi_m = hi;
            if (lwe) lo_m = lo;
        end
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        cycle(0, 0, 5'd0, 32'h0, 0, 0, 32'h0, 32'h0, a1, a2, 1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 32; i++) gpr_m[i] = 32'h0;
        hi_m  = 32'h0;
        lo_m  = 32'h0;
        cnt_m = 32'h0;
        rst                = 1'b1;
        ifc.wb_to_rf_bus   = '0;
        ifc.wb_to_hilo_bus = '0;
        ifc.raddr1         = '0;
        ifc.raddr2         = '0;

        // reset with writes presented: storage starts unknown, so first cycle unchecked
        cycle(1, 1, 5'd5, 32'hCAFE_0001, 1, 1, 32'h9, 32'h8, 5'd5, 5'd6, 0);
        cycle(1, 1, 5'd6, 32'hCAFE_0002, 1, 1, 32'h7, 32'h6, 5'd5, 5'd9, 1);
        cycle(1, 1, 5'd9, 32'hCAFE_0003, 1, 0, 32'h5, 32'h4, 5'd1, 5'd9, 1);
        for (int i = 1; i < 32; i++) idle(5'(i), 5'(32 - i));

        // write then read
        cycle(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0, 5'd1, 5'd2, 1);
        idle(5'd5, 5'd0);

        // r0 protection
        cycle(0, 1, 5'd0, 32'h1234_5678, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 1);
        idle(5'd0, 5'd5);

        // same-cycle bypass on both ports
        cycle(0, 1, 5'd7, 32'h0000_0001, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 1);
        cycle(0, 1, 5'd7, 32'h0000_00AA, 0, 0, 32'h0, 32'h0, 5'd7, 5'd7, 1);
        idle(5'd7, 5'd7);

        // HI/LO independence, then both together
        cycle(0, 0, 5'd0, 32'h0, 0, 1, 32'h0, 32'h55, 5'd0, 5'd0, 1);
        cycle(0, 0, 5'd0, 32'h0, 1, 0, 32'h11, 32'h22, 5'd0, 5'd0, 1);
        idle(5'd0, 5'd0);
        cycle(0, 0, 5'd0, 32'h0, 1, 1, 32'h33, 32'h44, 5'd0, 5'd0, 1);
        idle(5'd0, 5'd0);

        // randomized traffic with occasional reset
        for (int n = 0; n < 600; n++) begin
            bit r, we, hwe, lwe;
            logic [4:0] wa, a1, a2;
            r   = ($urandom_range(0, 49) == 0);
            we  = ($urandom_range(0, 3) != 0);
            wa  = 5'($urandom_range(0, 31));
            hwe = $urandom_range(0, 1);
            lwe = $urandom_range(0, 1);
            a1  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            a2  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            cycle(r, we, wa, $urandom, hwe, lwe, $urandom, $urandom, a1, a2, 1);
        end

        // counter wrap: preload the counter to all ones, then one write to r3
        idle(5'd3, 5'd0);
        @(posedge clk);
        #1;
        force dut.commit_q = 32'hFFFF_FFFF;
        #1;
        release dut.commit_q;
        cnt_m = 32'hFFFF_FFFF;
        cycle(0, 1, 5'd3, 32'h0BAD_F00D, 0, 0, 32'h0, 32'h0, 5'd3, 5'd0, 1);
        idle(5'd3, 5'd3);
        cycle(0, 1, 5'd3, 32'h0000_0003, 1, 1, 32'h1, 32'h2, 5'd3, 5'd3, 1);
        idle(5'd3, 5'd0);

        // drain the scoreboard with a bounded wait
        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
        #6;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
